// File: rtl/jts16_tmap_pkg.sv
// Shared definitions for the tile-map SDRAM read arbiter: port indices,
// arbiter states and the round-robin successor helper.
package jts16_tmap_pkg;

    localparam int unsigned NPORTS = 5;

    localparam logic [2:0] PORT_CHAR = 3'd0;
    localparam logic [2:0] PORT_MAP1 = 3'd1;
    localparam logic [2:0] PORT_SCR1 = 3'd2;
    localparam logic [2:0] PORT_MAP2 = 3'd3;
    localparam logic [2:0] PORT_SCR2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic logic [2:0] port_next(input logic [2:0] idx);
        return (idx == PORT_SCR2) ? PORT_CHAR : idx + 3'd1;
    endfunction

endpackage

// File: rtl/jts16_tmap_slot.sv
// One requester cache entry: remembers the last fetched address and its data,
// and flags a hit when the requester still asks for that same address.
module jts16_tmap_slot #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] data_o,
    output logic          ok_o,
    output logic          pend_o
);

    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    always_comb begin
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_i) begin
            last_d  = wr_addr_i;
            data_d  = wr_data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o = data_q;
    assign ok_o   = cs_i & valid_q & (addr_i == last_q);
    assign pend_o = cs_i & ~ok_o;

endmodule

// File: rtl/jts16_tmap_arb.sv
// Round-robin arbiter feeding five tile/map/scroll requesters from a single
// SDRAM read port, with one outstanding read and a sticky rdy timeout flag.
module jts16_tmap_arb
    import jts16_tmap_pkg::*;
#(
    parameter logic [21:0] CHAR_OFFSET = 22'h0,
    parameter logic [21:0] MAP1_OFFSET = 22'h0,
    parameter logic [21:0] MAP2_OFFSET = 22'h0,
    parameter logic [21:0] SCR1_OFFSET = 22'h0,
    parameter logic [21:0] SCR2_OFFSET = 22'h0,
    parameter logic [5:0]  TOUT        = 6'd63
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        char_cs,
    input  logic        map1_cs,
    input  logic        scr1_cs,
    input  logic        map2_cs,
    input  logic        scr2_cs,

    input  logic [12:0] char_addr,
    input  logic [14:0] map1_addr,
    input  logic [16:0] scr1_addr,
    input  logic [14:0] map2_addr,
    input  logic [16:0] scr2_addr,

    output logic [31:0] char_data,
    output logic [15:0] map1_data,
    output logic [31:0] scr1_data,
    output logic [15:0] map2_data,
    output logic [31:0] scr2_data,

    output logic        char_ok,
    output logic        map1_ok,
    output logic        scr1_ok,
    output logic        map2_ok,
    output logic        scr2_ok,

    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din,

    output logic        bad
);

    state_e             st_q, st_d;
    logic [2:0]         win_q, win_d;
    logic [2:0]         rr_q, rr_d;
    logic [16:0]        laddr_q, laddr_d;
    logic [21:0]        saddr_q, saddr_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               bad_q, bad_d;

    logic [NPORTS-1:0]  pend;
    logic [NPORTS-1:0]  wr;
    logic               store;
    logic               found;
    logic [2:0]         pick;
    logic [2:0]         idx;
    logic [16:0]        sel_addr;
    logic [21:0]        sel_saddr;
    logic [15:0]        map_word;

    // Search begins one past the previous winner so every port gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            idx = port_next(idx);
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_saddr = '0;
        case (pick)
            PORT_CHAR: begin
                sel_addr  = {4'd0, char_addr};
                sel_saddr = CHAR_OFFSET + {8'd0, char_addr, 1'b0};
            end
            PORT_MAP1: begin
                sel_addr  = {2'd0, map1_addr};
                sel_saddr = MAP1_OFFSET + {7'd0, map1_addr[14:1], 1'b0};
            end
            PORT_SCR1: begin
                sel_addr  = scr1_addr;
                sel_saddr = SCR1_OFFSET + {4'd0, scr1_addr, 1'b0};
            end
            PORT_MAP2: begin
                sel_addr  = {2'd0, map2_addr};
                sel_saddr = MAP2_OFFSET + {7'd0, map2_addr[14:1], 1'b0};
            end
            default: begin
                sel_addr  = scr2_addr;
                sel_saddr = SCR2_OFFSET + {4'd0, scr2_addr, 1'b0};
            end
        endcase
    end

    always_comb begin
        st_d    = st_q;
        win_d   = win_q;
        rr_d    = rr_q;
        laddr_d = laddr_q;
        saddr_d = saddr_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        store   = 1'b0;
        case (st_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    win_d   = pick;
                    rr_d    = pick;
                    laddr_d = sel_addr;
                    saddr_d = sel_saddr;
                    st_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (sdram_ack) st_d = ST_WAIT;
            end
            ST_WAIT: begin
                // rdy takes priority over a timeout landing in the same cycle
                if (sdram_rdy) begin
                    store = 1'b1;
                    st_d  = ST_IDLE;
                end else if (cnt_q == TOUT - 6'd1) begin
                    bad_d = 1'b1;
                    st_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= ST_IDLE;
            win_q   <= PORT_CHAR;
            rr_q    <= PORT_SCR2;
            laddr_q <= '0;
            saddr_q <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            laddr_q <= laddr_d;
            saddr_q <= saddr_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NPORTS; k++) begin
            wr[k] = store && (win_q == 3'(k));
        end
    end

    // Map entries are 16-bit halves of the fetched 32-bit word.
    assign map_word   = laddr_q[0] ? sdram_din[31:16] : sdram_din[15:0];
    assign sdram_req  = (st_q == ST_ISSUE);
    assign sdram_addr = saddr_q;
    assign bad        = bad_q;

    jts16_tmap_slot #(.AW(13), .DW(32)) u_char (
        .clk(clk), .rstn(rstn), .cs_i(char_cs), .addr_i(char_addr),
        .wr_i(wr[PORT_CHAR]), .wr_addr_i(laddr_q[12:0]), .wr_data_i(sdram_din),
        .data_o(char_data), .ok_o(char_ok), .pend_o(pend[PORT_CHAR])
    );

    jts16_tmap_slot #(.AW(15), .DW(16)) u_map1 (
        .clk(clk), .rstn(rstn), .cs_i(map1_cs), .addr_i(map1_addr),
        .wr_i(wr[PORT_MAP1]), .wr_addr_i(laddr_q[14:0]), .wr_data_i(map_word),
        .data_o(map1_data), .ok_o(map1_ok), .pend_o(pend[PORT_MAP1])
    );

    jts16_tmap_slot #(.AW(17), .DW(32)) u_scr1 (
        .clk(clk), .rstn(rstn), .cs_i(scr1_cs), .addr_i(scr1_addr),
        .wr_i(wr[PORT_SCR1]), .wr_addr_i(laddr_q), .wr_data_i(sdram_din),
        .data_o(scr1_data), .ok_o(scr1_ok), .pend_o(pend[PORT_SCR1])
    );

    jts16_tmap_slot #(.AW(15), .DW(16)) u_map2 (
        .clk(clk), .rstn(rstn), .cs_i(map2_cs), .addr_i(map2_addr),
        .wr_i(wr[PORT_MAP2]), .wr_addr_i(laddr_q[14:0]), .wr_data_i(map_word),
        .data_o(map2_data), .ok_o(map2_ok), .pend_o(pend[PORT_MAP2])
    );

    jts16_tmap_slot #(.AW(17), .DW(32)) u_scr2 (
        .clk(clk), .rstn(rstn), .cs_i(scr2_cs), .addr_i(scr2_addr),
        .wr_i(wr[PORT_SCR2]), .wr_addr_i(laddr_q), .wr_data_i(sdram_din),
        .data_o(scr2_data), .ok_o(scr2_ok), .pend_o(pend[PORT_SCR2])
    );

endmodule

// File: tb/tb_jts16_tmap_arb.sv
// Bench for jts16_tmap_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the five cached requesters.
module tb_jts16_tmap_arb;

    localparam logic [21:0] OFF_CHAR = 22'h001000;
    localparam logic [21:0] OFF_MAP1 = 22'h020000;
    localparam logic [21:0] OFF_SCR1 = 22'h100000;
    localparam logic [21:0] OFF_MAP2 = 22'h000000;
    localparam logic [21:0] OFF_SCR2 = 22'h3F0000;
    localparam int          TOUT     = 63;

    logic        clk;
    logic        rstn;
    logic        cs_v [5];
    logic [16:0] ad_v [5];
    logic        sdram_ack, sdram_rdy;
    logic [31:0] sdram_din;

    logic [31:0] char_data, scr1_data, scr2_data;
    logic [15:0] map1_data, map2_data;
    logic        char_ok, map1_ok, scr1_ok, map2_ok, scr2_ok;
    logic        sdram_req, bad;
    logic [21:0] sdram_addr;

    jts16_tmap_arb #(
        .CHAR_OFFSET(OFF_CHAR), .MAP1_OFFSET(OFF_MAP1), .MAP2_OFFSET(OFF_MAP2),
        .SCR1_OFFSET(OFF_SCR1), .SCR2_OFFSET(OFF_SCR2), .TOUT(6'd63)
    ) dut (
        .clk(clk), .rstn(rstn),
        .char_cs(cs_v[0]), .map1_cs(cs_v[1]), .scr1_cs(cs_v[2]),
        .map2_cs(cs_v[3]), .scr2_cs(cs_v[4]),
        .char_addr(ad_v[0][12:0]), .map1_addr(ad_v[1][14:0]), .scr1_addr(ad_v[2]),
        .map2_addr(ad_v[3][14:0]), .scr2_addr(ad_v[4]),
        .char_data(char_data), .map1_data(map1_data), .scr1_data(scr1_data),
        .map2_data(map2_data), .scr2_data(scr2_data),
        .char_ok(char_ok), .map1_ok(map1_ok), .scr1_ok(scr1_ok),
        .map2_ok(map2_ok), .scr2_ok(scr2_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_din(sdram_din),
        .bad(bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [16:0] m_last [5];
    logic [31:0] m_data [5];
    bit          m_valid [5];
    int          m_rr, m_phase, m_cnt, m_win;
    logic [16:0] m_laddr;
    logic [21:0] m_saddr;
    bit          m_bad;

    // SDRAM responder policy
    int          ack_dly, rdy_dly;
    bit          no_rdy, rand_mode, force_rdy;
    logic [31:0] rsp_din;

    int n_vec, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int aw(input int k);
        case (k)
            0:       return 13;
            1, 3:    return 15;
            default: return 17;
        endcase
    endfunction

    function automatic logic [16:0] amask(input int k, input logic [31:0] v);
        logic [31:0] m;
        m = (32'd1 << aw(k)) - 32'd1;
        return 17'(v & m);
    endfunction

    function automatic logic [21:0] exp_saddr(input int k, input logic [16:0] a);
        longint s;
        case (k)
            0:       s = longint'(OFF_CHAR) + 2 * longint'(a);
            1:       s = longint'(OFF_MAP1) + 2 * (longint'(a) / 2);
            2:       s = longint'(OFF_SCR1) + 2 * longint'(a);
            3:       s = longint'(OFF_MAP2) + 2 * (longint'(a) / 2);
            default: s = longint'(OFF_SCR2) + 2 * longint'(a);
        endcase
        s = s % 4194304;
        return 22'(s);
    endfunction

    function automatic bit m_ok(input int k);
        return cs_v[k] && m_valid[k] && (m_last[k] == ad_v[k]);
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < 5; k++) if (cs_v[k] && !m_ok(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic dut_ok(input int k);
        case (k)
            0:       return char_ok;
            1:       return map1_ok;
            2:       return scr1_ok;
            3:       return map2_ok;
            default: return scr2_ok;
        endcase
    endfunction

    function automatic logic [31:0] dut_data(input int k);
        case (k)
            0:       return char_data;
            1:       return {16'd0, map1_data};
            2:       return scr1_data;
            3:       return {16'd0, map2_data};
            default: return scr2_data;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_last[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0;
        end
        m_rr = 4; m_phase = 0; m_cnt = 0; m_win = 0; m_bad = 1'b0;
    endtask

    // One clock: decide responder pulses, advance the model, clock, compare.
    task automatic step();
        bit ack, rdy;
        int w;
        ack = 1'b0; rdy = 1'b0;
        if (m_phase == 1) ack = (m_cnt == ack_dly);
        else if (m_phase == 2) rdy = !no_rdy && (m_cnt == rdy_dly);
        else if (rand_mode) begin
            ack = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) == 0);
        end
        if (force_rdy) rdy = 1'b1;
        sdram_ack = ack;
        sdram_rdy = rdy;
        sdram_din = rdy ? rsp_din : $urandom();
        case (m_phase)
            0: begin
                w = -1;
                for (int i = 1; i <= 5; i++) begin
                    int k;
                    k = (m_rr + i) % 5;
                    if (w < 0 && cs_v[k] && !m_ok(k)) w = k;
                end
                if (w >= 0) begin
                    m_win = w; m_rr = w; m_laddr = ad_v[w];
                    m_saddr = exp_saddr(w, ad_v[w]);
                    m_phase = 1; m_cnt = 0;
                    if (rand_mode) begin
                        ack_dly = $urandom_range(0, 3);
                        rdy_dly = $urandom_range(0, 6);
                        no_rdy  = ($urandom_range(0, 39) == 0);
                        rsp_din = $urandom();
                    end
                end
            end
            1: if (ack) begin m_phase = 2; m_cnt = 0; end else m_cnt++;
            default: begin
                if (rdy) begin
                    m_valid[m_win] = 1'b1;
                    m_last[m_win]  = m_laddr;
                    if (m_win == 1 || m_win == 3)
                        m_data[m_win] = m_laddr[0] ? {16'd0, rsp_din[31:16]} : {16'd0, rsp_din[15:0]};
                    else
                        m_data[m_win] = rsp_din;
                    m_phase = 0;
                end else if (m_cnt == TOUT - 1) begin
                    m_bad = 1'b1; m_phase = 0;
                end else m_cnt++;
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        check("req", 32'(sdram_req), 32'(m_phase == 1));
        if (m_phase == 1) check("saddr", 32'(sdram_addr), 32'(m_saddr));
        check("bad", 32'(bad), 32'(m_bad));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ok%0d", k), 32'(dut_ok(k)), 32'(m_ok(k)));
            check($sformatf("data%0d", k), dut_data(k), m_data[k]);
        end
    endtask

    task automatic until_quiet(input int maxc);
        int n;
        n = 0;
        while ((m_phase != 0 || any_pending()) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check("quiet_bound", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0; sdram_ack = 1'b0; sdram_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        logic [21:0] gq[$];
        logic [21:0] eq[6];
        bit pr;
        int n;
        n_vec = 0; n_err = 0;
        rand_mode = 1'b0; force_rdy = 1'b0; no_rdy = 1'b0;
        ack_dly = 1; rdy_dly = 2; rsp_din = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        for (int k = 0; k < 5; k++) begin cs_v[k] = 1'b0; ad_v[k] = '0; end
        rstn = 1'b0;
        model_reset();
        cs_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_saddr", 32'(sdram_addr), 32'd0);
        check("rst_bad", 32'(bad), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_ok%0d", k), 32'(dut_ok(k)), 32'd0);
            check($sformatf("rst_data%0d", k), dut_data(k), 32'd0);
        end
        rstn = 1'b1;

        // Basic char fetch
        ad_v[0] = 17'h10;
        rsp_din = 32'hDEADBEEF;
        step();
        check("char_saddr", 32'(sdram_addr), 32'h0000_1020);
        until_quiet(50);
        check("char_ok", 32'(char_ok), 32'd1);
        check("char_data", char_data, 32'hDEADBEEF);

        // Round-robin order from reset, char re-request goes to the back
        do_reset();
        ad_v[0] = 17'h11; ad_v[1] = 17'h0005; ad_v[2] = 17'h00040;
        ad_v[3] = 17'h7FFF; ad_v[4] = 17'h1FFFF;
        for (int k = 0; k < 5; k++) cs_v[k] = 1'b1;
        rsp_din = 32'h12345678;
        eq[0] = exp_saddr(0, 17'h11);    eq[1] = exp_saddr(1, 17'h0005);
        eq[2] = exp_saddr(2, 17'h00040); eq[3] = exp_saddr(3, 17'h7FFF);
        eq[4] = exp_saddr(4, 17'h1FFFF); eq[5] = exp_saddr(0, 17'h12);
        pr = 1'b0; n = 0;
        while (!m_ok(0) && n < 100) begin
            step();
            if (sdram_req && !pr) gq.push_back(sdram_addr);
            pr = sdram_req; n++;
        end
        ad_v[0] = 17'h12;
        while ((m_phase != 0 || any_pending()) && n < 200) begin
            step();
            if (sdram_req && !pr) gq.push_back(sdram_addr);
            pr = sdram_req; n++;
        end
        check("grant_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            check($sformatf("grant%0d", i), 32'(gq[i]), 32'(eq[i]));

        // Map half-word selection
        ad_v[1] = 17'h0003; rsp_din = 32'hAAAA5555;
        until_quiet(50);
        check("map1_hi", 32'(map1_data), 32'h0000AAAA);
        ad_v[1] = 17'h0002;
        #1 check("map1_ok_drop", 32'(map1_ok), 32'd0);
        until_quiet(50);
        check("map1_lo", 32'(map1_data), 32'h00005555);

        // rdy timeout sets bad, port re-requests
        ad_v[2] = 17'h00077; no_rdy = 1'b1; n = 0;
        while (!m_bad && n < 200) begin step(); n++; end
        check("to_bad", 32'(bad), 32'd1);
        check("to_ok", 32'(scr1_ok), 32'd0);
        step();
        check("to_rereq", 32'(sdram_req), 32'd1);
        no_rdy = 1'b0;
        until_quiet(50);

        // Address change while the read is in flight
        rdy_dly = 4; ad_v[2] = 17'h00100; rsp_din = 32'hCAFEF00D; n = 0;
        while (m_phase != 2 && n < 50) begin step(); n++; end
        ad_v[2] = 17'h00101;
        until_quiet(100);
        check("scr1_final_ok", 32'(scr1_ok), 32'd1);

        // Reset during WAIT, late rdy afterwards is ignored
        rdy_dly = 10; ad_v[4] = 17'h00AAA; n = 0;
        while (m_phase != 2 && n < 50) begin step(); n++; end
        step(); step();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_req", 32'(sdram_req), 32'd0);
        for (int k = 0; k < 5; k++)
            check($sformatf("mid_rst_ok%0d", k), 32'(dut_ok(k)), 32'd0);
        model_reset();
        sdram_ack = 1'b0; sdram_rdy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        force_rdy = 1'b1;
        step();
        force_rdy = 1'b0;
        check("late_rdy_scr2", 32'(scr2_ok), 32'd0);
        rdy_dly = 1;
        until_quiet(200);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 2) == 0) cs_v[k] = ~cs_v[k];
                    else if ($urandom_range(0, 7) == 0) ad_v[k] = amask(k, $urandom());
                    else ad_v[k] = amask(k, $urandom_range(0, 3));
                end
            end
            step();
        end

        sdram_ack = 1'b0; sdram_rdy = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jts16_tmap_arb.md
JTS16_TMAP_ARB -- requirements
Module: jts16_tmap_arb

Interface
REQ-001 Parameter CHAR_OFFSET, 22'h0, SDRAM 16-bit-word base for char port.
REQ-002 Parameter MAP1_OFFSET / MAP2_OFFSET / SCR1_OFFSET / SCR2_OFFSET, 22'h0 each, per-port SDRAM word base.
REQ-003 Parameter TOUT, 6'd63, cycles to wait for sdram_rdy after sdram_ack before abort.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 char_cs/map1_cs/scr1_cs/map2_cs/scr2_cs  in  1 each  port request level.
REQ-007 char_addr 13, map1_addr/map2_addr 15, scr1_addr/scr2_addr 17  in  port addresses; char/scr in 32-bit units, map in 16-bit units.
REQ-008 char_data/scr1_data/scr2_data  out  32; map1_data/map2_data  out  16; returned data.
REQ-009 char_ok/map1_ok/scr1_ok/map2_ok/scr2_ok  out  1 each  data valid for current address.
REQ-010 sdram_req  out  1  read request level; sdram_addr  out  22  word address, always even.
REQ-011 sdram_ack  in  1  request accepted pulse; sdram_rdy  in  1  data valid pulse; sdram_din  in  32.
REQ-012 bad  out  1  sticky timeout flag.

Function
REQ-013 Each port holds last_addr, data, valid; x_ok = x_cs & valid & (x_addr==last_addr), combinational.
REQ-014 Port pending = x_cs & ~x_ok; pending never cleared by arbiter except by serving.
REQ-015 SDRAM address: char = CHAR_OFFSET+{char_addr,0}; scr = SCRn_OFFSET+{scr_addr,0}; map = MAPn_OFFSET+{map_addr[14:1],0}; sum truncated to 22 bits, wraps.
REQ-016 Map data = map_addr[0] ? sdram_din[31:16] : sdram_din[15:0], selected with the latched address bit.
REQ-017 FSM states IDLE, ISSUE, WAIT; encoded in package.
REQ-018 IDLE: if any pending, select round-robin winner, latch index and address, go ISSUE next cycle; order char(0), map1(1), scr1(2), map2(3), scr2(4); search starts at last winner+1 mod 5.
REQ-019 ISSUE: sdram_req=1, sdram_addr stable; on sdram_ack go WAIT, sdram_req=0 same edge; no timeout in ISSUE.
REQ-020 WAIT: on sdram_rdy write sdram_din and latched address into winner slot, valid=1, go IDLE; x_ok visible cycle after sdram_rdy.
REQ-021 WAIT: counter increments each cycle; reaching TOUT without sdram_rdy sets bad=1, slot unchanged, go IDLE; rdy and timeout same cycle: rdy wins.
REQ-022 Port address change during ISSUE/WAIT: transaction completes, stored with latched address, so ok stays low and port re-pends.
REQ-023 Port cs drop during ISSUE/WAIT: transaction completes and is stored; no cancellation.
REQ-024 sdram_ack/rdy outside ISSUE/WAIT ignored.
REQ-025 Minimum pending-to-sdram_req latency 1 cycle; one outstanding transaction maximum.

Reset
REQ-026 rstn low: state IDLE, sdram_req=0, sdram_addr=0, all valid=0, all data=0, all ok=0, rr pointer = scr2 (so char searched first), counter=0, bad=0.
REQ-027 Reset mid-transaction aborts immediately; late sdram_rdy after release ignored.

Structure
REQ-028 Package jts16_tmap_pkg holds state enum, port index constants (0-4), NPORTS=5.
REQ-029 Sub-module jts16_tmap_slot (last_addr/data/valid/ok compare) instantiated five times; offsets stay parameters of the top.

Verification
REQ-030 Reset, char_cs=1 addr 13'h10, CHAR_OFFSET 22'h1000 -> sdram_addr 22'h1020, ack then rdy din 32'hDEADBEEF -> char_ok=1, char_data 32'hDEADBEEF next cycle.
REQ-031 All five cs=1 simultaneously -> grant order char, map1, scr1, map2, scr2; re-asserting char after its service then waits for remaining four.
REQ-032 map1_addr 15'h0003, din 32'hAAAA5555 -> map1_data 16'hAAAA; then addr 15'h0002 -> map1_ok=0, new request, data 16'h5555.
REQ-033 Ack given, no rdy for 63 cycles -> bad=1, FSM IDLE, port re-requested, ok remains 0.
REQ-034 scr1_addr changed during WAIT -> stored data not flagged ok; second request with new address issued.
REQ-035 rstn low during WAIT -> sdram_req=0 and all ok=0 immediately; subsequent rdy pulse leaves valid=0.
